// File: rtl/dec_stream.sv
// dec_stream: pipelined binary-to-N decoder (one-hot, thermometer, active-low one-hot)
// with valid/ready handshakes on both sides. A main register plus a skid register
// sustain one transfer per cycle under back-pressure. There is no combinational path
// from the index to Y.
module dec_stream #(
    parameter int unsigned W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [W-1:0]          I,
    input  logic                  En,
    input  logic [1:0]            Mode,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [(1 << W)-1:0]   Y,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int unsigned N = 1 << W;

    typedef enum logic [1:0] {
        StEmpty,
        StOne,
        StTwo
    } state_e;

    state_e         state_q;
    logic [N-1:0]   main_q;
    logic [N-1:0]   skid_q;
    logic           out_valid_q;
    logic           skid_valid_q;
    logic [N-1:0]   dec_word;
    logic           in_xfer;
    logic           out_xfer;

    // Build the decode word for index k in the selected style.
    function automatic logic [N-1:0] decode_word(input logic [W-1:0] k, input logic en,
                                                 input logic [1:0] mode);
        logic [N-1:0] w;
        w = '0;
        if (en) begin
            for (int unsigned b = 0; b < N; b++) begin
                case (mode)
                    2'b00:   w[b] = (b[W-1:0] == k);
                    2'b01:   w[b] = (b[W-1:0] <= k);
                    2'b10:   w[b] = (b[W-1:0] != k);
                    default: w[b] = 1'b0;
                endcase
            end
        end
        return w;
    endfunction

    // Decode at acceptance; handshake qualifiers depend only on registered state.
    always_comb begin
        dec_word  = decode_word(I, En, Mode);
        in_ready  = rst_n & ~skid_valid_q;
        in_xfer   = in_valid & in_ready;
        out_xfer  = out_valid_q & out_ready;
        out_valid = out_valid_q;
        Y         = out_valid_q ? main_q : '0;
    end

    // Buffer FSM: reset discards everything, otherwise move words main <- skid <- input.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StEmpty;
            main_q       <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (in_xfer) begin
                        main_q      <= dec_word;
                        out_valid_q <= 1'b1;
                        state_q     <= StOne;
                    end
                end
                StOne: begin
                    if (in_xfer && out_xfer) begin
                        main_q <= dec_word;
                    end else if (in_xfer) begin
                        skid_q       <= dec_word;
                        skid_valid_q <= 1'b1;
                        state_q      <= StTwo;
                    end else if (out_xfer) begin
                        main_q      <= '0;
                        out_valid_q <= 1'b0;
                        state_q     <= StEmpty;
                    end
                end
                StTwo: begin
                    if (out_xfer) begin
                        main_q       <= skid_q;
                        skid_q       <= '0;
                        skid_valid_q <= 1'b0;
                        state_q      <= StOne;
                    end
                end
                default: begin
                    state_q      <= StEmpty;
                    main_q       <= '0;
                    skid_q       <= '0;
                    out_valid_q  <= 1'b0;
                    skid_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dec_stream.sv
// Scoreboard bench for dec_stream: accepted words push their hand-computed or modelled
// expectation, a negedge monitor pops and compares every output transfer.
module tb_dec_stream;

    logic        clk;
    logic        rst_n;
    logic [4:0]  I_s;
    logic        En_s;
    logic [1:0]  Mode_s;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] Y;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] exp_cur;

    logic [2:0]  i3;
    logic        en3;
    logic [1:0]  mode3;
    logic        iv3;
    logic        ir3;
    logic [7:0]  y3;
    logic        ov3;
    logic        or3;

    int errors;
    int checks;
    int n_push;
    int n_pop;
    logic [31:0] exp_q[$];
    logic        prev_stall;
    logic [31:0] prev_y;

    dec_stream #(.W(5)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .I         (I_s),
        .En        (En_s),
        .Mode      (Mode_s),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Y         (Y),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    dec_stream #(.W(3)) u_dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .I         (i3),
        .En        (en3),
        .Mode      (mode3),
        .in_valid  (iv3),
        .in_ready  (ir3),
        .Y         (y3),
        .out_valid (ov3),
        .out_ready (or3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference decode written independently of the RTL loop.
    function automatic logic [31:0] model(input logic [4:0] i, input logic en,
                                          input logic [1:0] m);
        logic [32:0] t;
        logic [31:0] one;
        one = 32'h1 << i;
        t   = (33'h1 << ({1'b0, i} + 6'd1)) - 33'h1;
        if (!en) return 32'h0;
        case (m)
            2'b00:   return one;
            2'b01:   return t[31:0];
            2'b10:   return ~one;
            default: return 32'h0;
        endcase
    endfunction

    // Present one word and hold it until accepted. Called and returns at posedge+1.
    task automatic send(input logic [4:0] i, input logic en, input logic [1:0] m,
                        input logic [31:0] e);
        int n;
        n        = 0;
        I_s      = i;
        En_s     = en;
        Mode_s   = m;
        exp_cur  = e;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready got 0 expected 1 for index %0d", i);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 500) begin
            n++;
            @(posedge clk);
        end
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: pending got %0d expected 0", exp_q.size());
        end
    endtask

    // Monitor: transfers are decided by values stable across the negedge.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", {63'b0, out_valid}, 64'h1);
                chk("stall_stable", {32'b0, Y}, {32'b0, prev_y});
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(exp_cur);
                n_push++;
            end
            if (out_valid && out_ready) begin
                n_pop++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %h expected no word", Y);
                end else begin
                    chk("scoreboard", {32'b0, Y}, {32'b0, exp_q.pop_front()});
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_y     = Y;
        end
    end

    initial begin
        errors = 0; checks = 0; n_push = 0; n_pop = 0;
        prev_stall = 1'b0; prev_y = '0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        I_s = '0; En_s = 1'b0; Mode_s = '0; exp_cur = '0;
        i3 = '0; en3 = 1'b0; mode3 = '0; iv3 = 1'b0; or3 = 1'b1;

        // Reset state over three cycles.
        repeat (3) begin
            @(negedge clk);
            chk("rst_y", {32'b0, Y}, 64'h0);
            chk("rst_valid", {63'b0, out_valid}, 64'h0);
            chk("rst_in_ready", {63'b0, in_ready}, 64'h0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("release_in_ready", {63'b0, in_ready}, 64'h1);
        @(posedge clk);
        #1;

        // W=3 boundary: I=7, active-low one-hot.
        i3 = 3'd7; en3 = 1'b1; mode3 = 2'b10; iv3 = 1'b1;
        @(posedge clk);
        #1;
        iv3 = 1'b0;
        @(negedge clk);
        chk("w3_y", {56'b0, y3}, 64'h7F);
        chk("w3_valid", {63'b0, ov3}, 64'h1);
        @(posedge clk);
        #1;

        // Basic decode with one-cycle latency.
        send(5'd19, 1'b1, 2'b00, 32'h0008_0000);
        @(negedge clk);
        chk("basic_valid", {63'b0, out_valid}, 64'h1);
        chk("basic_y", {32'b0, Y}, 64'h0008_0000);
        @(posedge clk);
        #1;

        // Mode sweep and boundaries, streamed back-to-back.
        send(5'd3, 1'b1, 2'b01, 32'h0000_000F);
        send(5'd3, 1'b1, 2'b10, 32'hFFFF_FFF7);
        send(5'd3, 1'b1, 2'b11, 32'h0000_0000);
        send(5'd3, 1'b0, 2'b10, 32'h0000_0000);
        send(5'd0, 1'b1, 2'b01, 32'h0000_0001);
        send(5'd31, 1'b1, 2'b01, 32'hFFFF_FFFF);
        send(5'd31, 1'b1, 2'b00, 32'h8000_0000);
        drain();

        // Back-pressure: I=1 accepted, then out_ready drops while I=2 is absorbed.
        I_s = 5'd1; En_s = 1'b1; Mode_s = 2'b00; exp_cur = 32'h2; in_valid = 1'b1;
        @(negedge clk);
        chk("bp_ready0", {63'b0, in_ready}, 64'h1);
        @(posedge clk);
        #1;
        I_s = 5'd2; exp_cur = 32'h4; out_ready = 1'b0;
        @(negedge clk);
        chk("bp_ready1", {63'b0, in_ready}, 64'h1);
        chk("bp_y1", {32'b0, Y}, 64'h2);
        @(posedge clk);
        #1;
        I_s = 5'd3; exp_cur = 32'h8;
        repeat (3) begin
            @(negedge clk);
            chk("bp_full_ready", {63'b0, in_ready}, 64'h0);
            chk("bp_hold_y", {32'b0, Y}, 64'h2);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        fork
            begin
                send(5'd3, 1'b1, 2'b00, 32'h8);
                send(5'd4, 1'b1, 2'b00, 32'h10);
            end
            begin
                logic [31:0] seq[4];
                seq[0] = 32'h2; seq[1] = 32'h4; seq[2] = 32'h8; seq[3] = 32'h10;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    chk("bp_nogap_valid", {63'b0, out_valid}, 64'h1);
                    chk("bp_order_y", {32'b0, Y}, {32'b0, seq[k]});
                end
            end
        join
        drain();

        // Random stress against the reference model.
        for (int c = 0; c < 10000; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            I_s       = 5'($urandom);
            En_s      = 1'($urandom_range(0, 1));
            Mode_s    = 2'($urandom);
            exp_cur   = model(I_s, En_s, Mode_s);
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        drain();
        chk("push_pop_balance", 64'(n_pop), 64'(n_push));

        // Reset with two words held; neither may ever appear.
        out_ready = 1'b0;
        send(5'd6, 1'b1, 2'b00, 32'h40);
        send(5'd7, 1'b1, 2'b00, 32'h80);
        @(negedge clk);
        chk("two_in_ready", {63'b0, in_ready}, 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        I_s = 5'd9; exp_cur = 32'h200; in_valid = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", {63'b0, out_valid}, 64'h0);
        chk("mid_rst_y", {32'b0, Y}, 64'h0);
        chk("mid_rst_in_ready", {63'b0, in_ready}, 64'h1);
        repeat (8) @(posedge clk);
        #1;
        send(5'd10, 1'b1, 2'b01, 32'h0000_07FF);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
